// File: rtl/ascon_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_permutation_ctrl
//
// Sequential controller for the ASCON permutation. It owns the 320-bit state
// register and the 4-bit round counter. Both feed an external combinational
// round chain (constant addition -> substitution -> linear diffusion). The
// chain's output is captured once per clock until round 11 has been applied.
// After that the final state is presented together with a one-cycle done
// pulse.
//
// Starting rounds: 0 gives p12, 4 gives p8 and 6 gives p6. A run takes
// 12 - start_round cycles in RUN, followed by one DONE cycle.
//
// State layout: word x_i occupies state[64*i +: 64]. Word x2 is therefore
// bits [191:128].
//
// Ports
//   clock_i         in   1    system clock, rising edge
//   resetb_i        in   1    asynchronous active-low reset
//   start_i         in   1    request a permutation; sampled on rising edge
//   start_round_i   in   4    first round index (0..11); sampled with start_i
//   state_i         in   320  initial state; sampled with start_i
//   round_result_i  in   320  round chain output for (state_o, round_o)
//   state_o         out  320  state register
//   round_o         out  4    current round index
//   busy_o          out  1    high while rounds are executing
//   done_o          out  1    one-cycle pulse; final state valid on state_o
// ---------------------------------------------------------------------------
module ascon_permutation_ctrl (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   start_round_i,
  input  logic [319:0] state_i,
  input  logic [319:0] round_result_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] LAST_ROUND = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } t_fsm;

  t_fsm           r_fsm;
  t_fsm           w_fsm_next;
  logic [319:0]   r_state;
  logic [319:0]   w_state_next;
  logic [3:0]     r_round;
  logic [3:0]     w_round_next;
  logic           w_start_ok;

  // A start naming a round index beyond the last round is dropped entirely.
  // It must not even disturb the state register.
  assign w_start_ok = start_i && (start_round_i <= LAST_ROUND);

  // State register, with asynchronous abort to IDLE.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_state <= w_state_next;
      r_round <= w_round_next;
    end
  end

  // Next-state logic. By default every register holds its value, so the
  // final state stays readable in IDLE until the next accepted start.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_state_next = r_state;
    w_round_next = r_round;

    case (r_fsm)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          // Accepting in DONE gives back-to-back runs with no bubble.
          w_fsm_next   = S_RUN;
          w_state_next = state_i;
          w_round_next = start_round_i;
        end else begin
          w_fsm_next = S_IDLE;
        end
      end

      S_RUN: begin
        // start_i is deliberately ignored here. There is no restart and
        // no queuing of a second request.
        w_state_next = round_result_i;
        if (r_round == LAST_ROUND) begin
          // The counter parks at 11 rather than stepping to 12.
          w_fsm_next = S_DONE;
        end else begin
          w_round_next = r_round + 4'd1;
        end
      end

      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase
  end

  // Status outputs are decoded only from registered FSM state. This keeps
  // any combinational path from the inputs away from busy_o and done_o.
  assign busy_o  = (r_fsm == S_RUN);
  assign done_o  = (r_fsm == S_DONE);
  assign state_o = r_state;
  assign round_o = r_round;

endmodule
